sd_dma_sched: RTL and testbench
===============================

Name: sd_dma_sched

Overview:
- Multi-block sequencer for the SD DMA engine.
- Takes one MCU command (start SRAM address, block count, first-block start, last-block end) and issues one DMA trigger per 512-byte block.
- Applies partial start only to the first block and partial end only to the last block.
- Owns the SRAM write address counter and reports busy, done and timeout status to the MCU register file.

Parameters:
- ADDR_W, 24, SRAM address width.
- CNT_W, 16, block-count width.
- EN_HOLD, 4, CLK cycles the DMA_EN level is held high per trigger; must be ≥3 to pass the engine's 2-flop edge detector.
- TMO_W, 12, width of the wait-for-status timeout counter; timeout fires at 2^TMO_W-1.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous active-low reset
- CMD_START  in  1  one-cycle command strobe; ignored while BUSY=1
- CMD_ABORT  in  1  one-cycle abort strobe
- CMD_ADDR  in  ADDR_W  SRAM address of the first byte written
- CMD_BLOCKS  in  CNT_W  number of blocks; 0 = no-op
- CMD_FIRST_START  in  11  partial-window start for block 0, in engine cycle units 0..1024
- CMD_LAST_END  in  11  partial-window end for the last block, 0..1024
- BLK_READY  in  1  one-cycle pulse from the start-bit detector: card is sending the next block
- DMA_STATUS  in  1  engine busy flag
- DMA_NEXTADDR  in  1  engine address-advance strobe
- DMA_EN  out  1  engine trigger level
- DMA_PARTIAL  out  1  engine partial-mode select
- DMA_PARTIAL_START  out  11  engine window start
- DMA_PARTIAL_END  out  11  engine window end
- SRAM_ADDR  out  ADDR_W  current SRAM write address
- BUSY  out  1  command in progress
- DONE  out  1  one-cycle pulse: command completed (normal or aborted)
- ERR  out  1  sticky timeout flag; cleared by the next accepted CMD_START
- BLOCKS_LEFT  out  CNT_W  blocks not yet completed

Behaviour:
- Reset values: all outputs 0; SRAM_ADDR=0; FSM in IDLE.
- Reset mid-command drops DMA_EN the following cycle. No DONE pulse is produced.

FSM states: IDLE, WAIT_RDY, TRIG, WAIT_BUSY, WAIT_IDLE, NEXT.
- IDLE, CMD_START with CMD_BLOCKS≠0:
  - latch command fields; SRAM_ADDR<=CMD_ADDR; BLOCKS_LEFT<=CMD_BLOCKS; ERR<=0; BUSY<=1
  - first<=1; go WAIT_RDY
- IDLE, CMD_START with CMD_BLOCKS=0: DONE pulses next cycle; BUSY stays 0.
- WAIT_RDY: on BLK_READY go TRIG.
  - DMA_PARTIAL=1 when the current block is first or last (BLOCKS_LEFT==1); otherwise 0.
  - DMA_PARTIAL_START = first ? CMD_FIRST_START : 0.
  - DMA_PARTIAL_END = last ? CMD_LAST_END : 1024.
  - These three outputs are registered and stable from WAIT_RDY entry until WAIT_IDLE exit.
- TRIG: DMA_EN=1 for exactly EN_HOLD cycles, then go WAIT_BUSY.
- WAIT_BUSY: wait for DMA_STATUS=1, then go WAIT_IDLE.
- WAIT_IDLE: wait for DMA_STATUS=0, then go NEXT.
- NEXT (1 cycle): BLOCKS_LEFT<=BLOCKS_LEFT-1; first<=0.
  - If the decremented count is 0: BUSY<=0, DONE pulse, go IDLE.
  - Otherwise go WAIT_RDY.
- Timeout: a counter clears on every state entry and runs in WAIT_BUSY and WAIT_IDLE. At all-ones: ERR<=1, DMA_EN<=0, DONE pulse, BUSY<=0, go IDLE.
- Abort:
  - CMD_ABORT in WAIT_RDY: go IDLE next cycle with DONE pulse.
  - CMD_ABORT in TRIG, WAIT_BUSY or WAIT_IDLE: latch the request. Finish the current block through WAIT_IDLE, then terminate as above. The engine cannot be stopped mid-block.
- SRAM_ADDR:
  - increments by 1 on every CLK with DMA_NEXTADDR=1 while BUSY; wraps modulo 2^ADDR_W
  - does not change outside BUSY
  - CMD_START load takes priority over a simultaneous increment
- Simultaneous CMD_START and CMD_ABORT in IDLE: the start is accepted, then the abort takes effect in WAIT_RDY on the next cycle.
- BLK_READY outside WAIT_RDY is ignored; it is not queued.

Decomposition:
- Shared package sd_dma_pkg:
  - state enum
  - SD_BLK_CYCLES=1024
  - default EN_HOLD value
- One natural sub-module, sd_dma_addrgen: loadable ADDR_W counter with increment enable. This keeps address logic reusable by a future write-direction scheduler.

Test Plan:
- Single full block: CMD_BLOCKS=1, CMD_FIRST_START=0, CMD_LAST_END=1024, CMD_ADDR=0x001000, engine model emits 512 NEXTADDR strobes → DMA_PARTIAL=1 with 0/1024, exactly one 4-cycle DMA_EN, SRAM_ADDR=0x001200, one DONE, ERR=0.
- Three blocks, CMD_FIRST_START=100, CMD_LAST_END=600 → block0 window 100/1024, block1 PARTIAL=0, block2 window 0/600; BLOCKS_LEFT steps 3→2→1→0; DONE only after the third STATUS fall.
- Timeout: TMO_W=4, engine never raises STATUS → ERR=1 and DONE 15 cycles after WAIT_BUSY entry; BUSY=0; next CMD_START clears ERR.
- Abort during block 1 of 4 → engine completes block 1; DONE follows its STATUS fall; no further DMA_EN; BLOCKS_LEFT=2.
- CMD_BLOCKS=0 → DONE next cycle, DMA_EN never asserted; CMD_START while BUSY is ignored (latched fields unchanged).
- Address wrap: CMD_ADDR=0xFFFFFE with 4 NEXTADDR strobes → SRAM_ADDR=0x000002; RST_N low mid-block → all outputs 0 the next cycle.

Source files
------------

// File: rtl/sd_dma_pkg.sv
// Shared types and constants for the SD DMA block scheduler.
package sd_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StTrig,
    StWaitBusy,
    StWaitIdle,
    StNext
  } sd_dma_state_e;

  // Engine cycles per 512-byte block; also the "full window" end value.
  localparam int unsigned SD_BLK_CYCLES   = 1024;
  localparam int unsigned EN_HOLD_DEFAULT = 4;

endpackage

// File: rtl/sd_dma_sched_if.sv
// Command, engine and status signals between the MCU/engine side and the block scheduler.
interface sd_dma_sched_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned CNT_W  = 16
);
  logic              CMD_START;
  logic              CMD_ABORT;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [CNT_W-1:0]  CMD_BLOCKS;
  logic [10:0]       CMD_FIRST_START;
  logic [10:0]       CMD_LAST_END;
  logic              BLK_READY;
  logic              DMA_STATUS;
  logic              DMA_NEXTADDR;
  logic              DMA_EN;
  logic              DMA_PARTIAL;
  logic [10:0]       DMA_PARTIAL_START;
  logic [10:0]       DMA_PARTIAL_END;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [CNT_W-1:0]  BLOCKS_LEFT;

  modport master (
    output CMD_START, CMD_ABORT, CMD_ADDR, CMD_BLOCKS, CMD_FIRST_START, CMD_LAST_END,
    output BLK_READY, DMA_STATUS, DMA_NEXTADDR,
    input  DMA_EN, DMA_PARTIAL, DMA_PARTIAL_START, DMA_PARTIAL_END,
    input  SRAM_ADDR, BUSY, DONE, ERR, BLOCKS_LEFT
  );

  modport slave (
    input  CMD_START, CMD_ABORT, CMD_ADDR, CMD_BLOCKS, CMD_FIRST_START, CMD_LAST_END,
    input  BLK_READY, DMA_STATUS, DMA_NEXTADDR,
    output DMA_EN, DMA_PARTIAL, DMA_PARTIAL_START, DMA_PARTIAL_END,
    output SRAM_ADDR, BUSY, DONE, ERR, BLOCKS_LEFT
  );
endinterface

// File: rtl/sd_dma_addrgen.sv
// Loadable SRAM address counter with increment enable; load wins over increment.
module sd_dma_addrgen #(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sd_dma_sched.sv
// Multi-block SD DMA sequencer: one engine trigger per block, partial windows on first/last block.
module sd_dma_sched
  import sd_dma_pkg::*;
#(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned EN_HOLD = EN_HOLD_DEFAULT,
  parameter int unsigned TMO_W   = 12
) (
  input logic           CLK,
  input logic           RST_N,
  sd_dma_sched_if.slave bus
);

  localparam int unsigned      HoldW    = (EN_HOLD > 1) ? $clog2(EN_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(EN_HOLD - 1);
  // Flags are registered, so firing one count early makes them visible as the count hits all-ones.
  localparam logic [TMO_W-1:0] TmoFire  = {{(TMO_W - 1){1'b1}}, 1'b0};
  localparam logic [10:0]      WinFull  = 11'(SD_BLK_CYCLES);

  sd_dma_state_e    state_q;
  logic             busy_q, done_q, err_q, en_q, part_q, abort_q;
  logic [10:0]      pstart_q, pend_q, last_end_q;
  logic [CNT_W-1:0] left_q;
  logic [HoldW-1:0] hold_q;
  logic [TMO_W-1:0] tmo_q;

  logic             start_ok;
  logic [CNT_W-1:0] left_dec;

  assign start_ok = (state_q == StIdle) && bus.CMD_START && (bus.CMD_BLOCKS != '0);
  assign left_dec = left_q - CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
      part_q     <= 1'b0;
      abort_q    <= 1'b0;
      pstart_q   <= '0;
      pend_q     <= '0;
      last_end_q <= '0;
      left_q     <= '0;
      hold_q     <= '0;
      tmo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          if (start_ok) begin
            last_end_q <= bus.CMD_LAST_END;
            left_q     <= bus.CMD_BLOCKS;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            // An abort arriving with the start is honoured once in WAIT_RDY.
            abort_q    <= bus.CMD_ABORT;
            part_q     <= 1'b1;
            pstart_q   <= bus.CMD_FIRST_START;
            pend_q     <= (bus.CMD_BLOCKS == CNT_W'(1)) ? bus.CMD_LAST_END : WinFull;
            state_q    <= StWaitRdy;
          end else if (bus.CMD_START) begin
            done_q <= 1'b1;
          end
        end

        StWaitRdy: begin
          if (bus.CMD_ABORT || abort_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (bus.BLK_READY) begin
            en_q    <= 1'b1;
            hold_q  <= '0;
            state_q <= StTrig;
          end
        end

        StTrig: begin
          if (bus.CMD_ABORT) abort_q <= 1'b1;
          if (hold_q == HoldLast) begin
            en_q    <= 1'b0;
            tmo_q   <= '0;
            state_q <= StWaitBusy;
          end else begin
            hold_q <= hold_q + HoldW'(1);
          end
        end

        StWaitBusy, StWaitIdle: begin
          if (bus.CMD_ABORT) abort_q <= 1'b1;
          if ((state_q == StWaitBusy) && bus.DMA_STATUS) begin
            tmo_q   <= '0;
            state_q <= StWaitIdle;
          end else if ((state_q == StWaitIdle) && !bus.DMA_STATUS) begin
            tmo_q   <= '0;
            state_q <= StNext;
          end else if (tmo_q == TmoFire) begin
            err_q   <= 1'b1;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        StNext: begin
          left_q <= left_dec;
          if ((left_dec == '0) || abort_q || bus.CMD_ABORT) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            part_q   <= (left_dec == CNT_W'(1));
            pstart_q <= '0;
            pend_q   <= (left_dec == CNT_W'(1)) ? last_end_q : WinFull;
            state_q  <= StWaitRdy;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  sd_dma_addrgen #(
    .ADDR_W (ADDR_W)
  ) u_addrgen (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (start_ok),
    .load_val (bus.CMD_ADDR),
    .inc      (busy_q && bus.DMA_NEXTADDR),
    .addr     (bus.SRAM_ADDR)
  );

  assign bus.DMA_EN            = en_q;
  assign bus.DMA_PARTIAL       = part_q;
  assign bus.DMA_PARTIAL_START = pstart_q;
  assign bus.DMA_PARTIAL_END   = pend_q;
  assign bus.BUSY              = busy_q;
  assign bus.DONE              = done_q;
  assign bus.ERR               = err_q;
  assign bus.BLOCKS_LEFT       = left_q;

endmodule

// File: tb/tb_sd_dma_sched.sv
// Directed bench for sd_dma_sched; a second instance with a 4-bit timeout shares the inputs.
module tb_sd_dma_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sd_dma_sched_if #(.ADDR_W(24), .CNT_W(16)) bus ();
  sd_dma_sched_if #(.ADDR_W(24), .CNT_W(16)) bus4 ();

  assign bus4.CMD_START       = bus.CMD_START;
  assign bus4.CMD_ABORT       = bus.CMD_ABORT;
  assign bus4.CMD_ADDR        = bus.CMD_ADDR;
  assign bus4.CMD_BLOCKS      = bus.CMD_BLOCKS;
  assign bus4.CMD_FIRST_START = bus.CMD_FIRST_START;
  assign bus4.CMD_LAST_END    = bus.CMD_LAST_END;
  assign bus4.BLK_READY       = bus.BLK_READY;
  assign bus4.DMA_STATUS      = bus.DMA_STATUS;
  assign bus4.DMA_NEXTADDR    = bus.DMA_NEXTADDR;

  sd_dma_sched #(.ADDR_W(24), .CNT_W(16), .EN_HOLD(4), .TMO_W(12)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  sd_dma_sched #(.ADDR_W(24), .CNT_W(16), .EN_HOLD(4), .TMO_W(4)) dut4 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus4.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.CMD_START = 0; bus.CMD_ABORT = 0; bus.CMD_ADDR = '0; bus.CMD_BLOCKS = '0;
    bus.CMD_FIRST_START = '0; bus.CMD_LAST_END = '0;
    bus.BLK_READY = 0; bus.DMA_STATUS = 0; bus.DMA_NEXTADDR = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_cmd(input logic [23:0] a, input logic [15:0] n,
                          input logic [10:0] fs, input logic [10:0] le);
    bus.CMD_ADDR = a; bus.CMD_BLOCKS = n; bus.CMD_FIRST_START = fs; bus.CMD_LAST_END = le;
    bus.CMD_START = 1'b1;
    tick();
    bus.CMD_START = 1'b0;
  endtask

  // Engine model: trigger, count DMA_EN cycles, busy with nstrobes address strobes, then idle.
  // Returns with the DUT sampled in its NEXT state.
  task automatic serve_block(input int nstrobes, output int en_cycles);
    bus.BLK_READY = 1'b1;
    tick();
    bus.BLK_READY = 1'b0;
    en_cycles = 0;
    for (int i = 0; i < 20 && bus.DMA_EN; i++) begin
      en_cycles++;
      tick();
    end
    bus.DMA_STATUS = 1'b1;
    tick();
    for (int i = 0; i < nstrobes; i++) begin
      bus.DMA_NEXTADDR = 1'b1;
      tick();
    end
    bus.DMA_NEXTADDR = 1'b0;
    bus.DMA_STATUS = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [66:0] obs;
    do_reset();
    obs = {bus.DMA_EN, bus.DMA_PARTIAL, bus.DMA_PARTIAL_START, bus.DMA_PARTIAL_END,
           bus.SRAM_ADDR, bus.BUSY, bus.DONE, bus.ERR, bus.BLOCKS_LEFT};
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
  endtask

  task automatic test_single_block();
    int en;
    do_reset();
    send_cmd(24'h001000, 16'd1, 11'd0, 11'd1024);
    checks++;
    if ({bus.DMA_PARTIAL, bus.DMA_PARTIAL_START, bus.DMA_PARTIAL_END} !== {1'b1, 11'd0, 11'd1024}) begin
      errors++; $display("FAIL single_window: got %b/%0d/%0d expected 1/0/1024",
                         bus.DMA_PARTIAL, bus.DMA_PARTIAL_START, bus.DMA_PARTIAL_END);
    end
    checks++;
    if (bus.BUSY !== 1'b1 || bus.SRAM_ADDR !== 24'h001000) begin
      errors++; $display("FAIL single_load: busy %b addr %h expected 1 001000", bus.BUSY, bus.SRAM_ADDR);
    end
    serve_block(512, en);
    checks++;
    if (en != 4) begin
      errors++; $display("FAIL single_en_len: got %0d expected 4", en);
    end
    tick();
    checks++;
    if ({bus.DONE, bus.BUSY, bus.ERR} !== 3'b100 || bus.SRAM_ADDR !== 24'h001200) begin
      errors++; $display("FAIL single_done: done/busy/err %b addr %h expected 100 001200",
                         {bus.DONE, bus.BUSY, bus.ERR}, bus.SRAM_ADDR);
    end
    tick();
    checks++;
    if (bus.DONE !== 1'b0) begin
      errors++; $display("FAIL single_done_pulse: got %b expected 0", bus.DONE);
    end
  endtask

  task automatic test_three_blocks();
    int en;
    do_reset();
    send_cmd(24'h000000, 16'd3, 11'd100, 11'd600);
    checks++;
    if ({bus.DMA_PARTIAL, bus.DMA_PARTIAL_START, bus.DMA_PARTIAL_END, bus.BLOCKS_LEFT}
        !== {1'b1, 11'd100, 11'd1024, 16'd3}) begin
      errors++; $display("FAIL three_blk0: got %b/%0d/%0d left %0d expected 1/100/1024 left 3",
                         bus.DMA_PARTIAL, bus.DMA_PARTIAL_START, bus.DMA_PARTIAL_END, bus.BLOCKS_LEFT);
    end
    serve_block(8, en);
    tick();
    checks++;
    if ({bus.DMA_PARTIAL, bus.DMA_PARTIAL_START, bus.DMA_PARTIAL_END, bus.BLOCKS_LEFT, bus.DONE}
        !== {1'b0, 11'd0, 11'd1024, 16'd2, 1'b0}) begin
      errors++; $display("FAIL three_blk1: got %b/%0d/%0d left %0d done %b expected 0/0/1024 left 2 done 0",
                         bus.DMA_PARTIAL, bus.DMA_PARTIAL_START, bus.DMA_PARTIAL_END,
                         bus.BLOCKS_LEFT, bus.DONE);
    end
    serve_block(8, en);
    tick();
    checks++;
    if ({bus.DMA_PARTIAL, bus.DMA_PARTIAL_START, bus.DMA_PARTIAL_END, bus.BLOCKS_LEFT, bus.DONE}
        !== {1'b1, 11'd0, 11'd600, 16'd1, 1'b0}) begin
      errors++; $display("FAIL three_blk2: got %b/%0d/%0d left %0d done %b expected 1/0/600 left 1 done 0",
                         bus.DMA_PARTIAL, bus.DMA_PARTIAL_START, bus.DMA_PARTIAL_END,
                         bus.BLOCKS_LEFT, bus.DONE);
    end
    serve_block(8, en);
    checks++;
    if (bus.DONE !== 1'b0 || bus.DMA_PARTIAL_END !== 11'd600) begin
      errors++; $display("FAIL three_before_done: done %b end %0d expected 0 600",
                         bus.DONE, bus.DMA_PARTIAL_END);
    end
    tick();
    checks++;
    if ({bus.DONE, bus.BUSY, bus.BLOCKS_LEFT, bus.SRAM_ADDR} !== {1'b1, 1'b0, 16'd0, 24'd24}) begin
      errors++; $display("FAIL three_done: done %b busy %b left %0d addr %0d expected 1 0 0 24",
                         bus.DONE, bus.BUSY, bus.BLOCKS_LEFT, bus.SRAM_ADDR);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    send_cmd(24'h000010, 16'd2, 11'd0, 11'd1024);
    bus.BLK_READY = 1'b1;
    tick();
    bus.BLK_READY = 1'b0;
    for (int i = 0; i < 20 && bus4.DMA_EN; i++) tick();
    n = 0;
    while (!bus4.DONE && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 15) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles expected 15", n);
    end
    checks++;
    if ({bus4.ERR, bus4.BUSY, bus4.DMA_EN} !== 3'b100) begin
      errors++; $display("FAIL timeout_flags: err/busy/en %b expected 100",
                         {bus4.ERR, bus4.BUSY, bus4.DMA_EN});
    end
    tick();
    checks++;
    if (bus4.ERR !== 1'b1 || bus4.DONE !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky: err %b done %b expected 1 0", bus4.ERR, bus4.DONE);
    end
    send_cmd(24'h000020, 16'd1, 11'd0, 11'd1024);
    checks++;
    if (bus4.ERR !== 1'b0 || bus4.BUSY !== 1'b1) begin
      errors++; $display("FAIL timeout_err_clear: err %b busy %b expected 0 1", bus4.ERR, bus4.BUSY);
    end
  endtask

  task automatic test_abort();
    int en;
    logic seen;
    do_reset();
    send_cmd(24'h000000, 16'd4, 11'd0, 11'd1024);
    serve_block(4, en);
    tick();
    bus.BLK_READY = 1'b1;
    tick();
    bus.BLK_READY = 1'b0;
    bus.CMD_ABORT = 1'b1;
    tick();
    bus.CMD_ABORT = 1'b0;
    for (int i = 0; i < 20 && bus.DMA_EN; i++) tick();
    bus.DMA_STATUS = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.DMA_NEXTADDR = 1'b1;
      tick();
    end
    bus.DMA_NEXTADDR = 1'b0;
    checks++;
    if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b1) begin
      errors++; $display("FAIL abort_finishes_block: done %b busy %b expected 0 1", bus.DONE, bus.BUSY);
    end
    bus.DMA_STATUS = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.DONE, bus.BUSY, bus.BLOCKS_LEFT} !== {1'b1, 1'b0, 16'd2}) begin
      errors++; $display("FAIL abort_done: done %b busy %b left %0d expected 1 0 2",
                         bus.DONE, bus.BUSY, bus.BLOCKS_LEFT);
    end
    seen = 1'b0;
    bus.BLK_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.BLK_READY = 1'b0;
      seen |= bus.DMA_EN;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_more_en: got %b expected 0", seen);
    end
    // Abort while waiting for the card.
    send_cmd(24'h000000, 16'd3, 11'd0, 11'd1024);
    bus.CMD_ABORT = 1'b1;
    tick();
    bus.CMD_ABORT = 1'b0;
    checks++;
    if ({bus.DONE, bus.BUSY} !== 2'b10) begin
      errors++; $display("FAIL abort_wait_rdy: done/busy %b expected 10", {bus.DONE, bus.BUSY});
    end
    // Start and abort together: start accepted, abort lands one cycle later.
    bus.CMD_ABORT = 1'b1;
    send_cmd(24'h000000, 16'd3, 11'd0, 11'd1024);
    bus.CMD_ABORT = 1'b0;
    checks++;
    if ({bus.DONE, bus.BUSY} !== 2'b01) begin
      errors++; $display("FAIL start_abort_accept: done/busy %b expected 01", {bus.DONE, bus.BUSY});
    end
    tick();
    checks++;
    if ({bus.DONE, bus.BUSY} !== 2'b10) begin
      errors++; $display("FAIL start_abort_done: done/busy %b expected 10", {bus.DONE, bus.BUSY});
    end
  endtask

  task automatic test_zero_and_busy_start();
    int en;
    do_reset();
    send_cmd(24'h000300, 16'd0, 11'd5, 11'd6);
    checks++;
    if ({bus.DONE, bus.BUSY, bus.DMA_EN} !== 3'b100) begin
      errors++; $display("FAIL zero_blocks: done/busy/en %b expected 100",
                         {bus.DONE, bus.BUSY, bus.DMA_EN});
    end
    send_cmd(24'h000100, 16'd2, 11'd50, 11'd700);
    send_cmd(24'h000555, 16'd5, 11'd7, 11'd9);
    checks++;
    if ({bus.SRAM_ADDR, bus.BLOCKS_LEFT, bus.DMA_PARTIAL_START} !== {24'h000100, 16'd2, 11'd50}) begin
      errors++; $display("FAIL busy_start_ignored: addr %h left %0d start %0d expected 000100 2 50",
                         bus.SRAM_ADDR, bus.BLOCKS_LEFT, bus.DMA_PARTIAL_START);
    end
    serve_block(2, en);
    tick();
    checks++;
    if ({bus.DMA_PARTIAL, bus.DMA_PARTIAL_END} !== {1'b1, 11'd700}) begin
      errors++; $display("FAIL busy_start_last_end: partial %b end %0d expected 1 700",
                         bus.DMA_PARTIAL, bus.DMA_PARTIAL_END);
    end
  endtask

  task automatic test_wrap_and_reset();
    int en;
    logic [66:0] obs;
    do_reset();
    send_cmd(24'hFFFFFE, 16'd1, 11'd0, 11'd1024);
    serve_block(4, en);
    tick();
    checks++;
    if (bus.SRAM_ADDR !== 24'h000002) begin
      errors++; $display("FAIL addr_wrap: got %h expected 000002", bus.SRAM_ADDR);
    end
    bus.DMA_NEXTADDR = 1'b1;
    tick();
    tick();
    bus.DMA_NEXTADDR = 1'b0;
    checks++;
    if (bus.SRAM_ADDR !== 24'h000002) begin
      errors++; $display("FAIL addr_idle_hold: got %h expected 000002", bus.SRAM_ADDR);
    end
    send_cmd(24'h123456, 16'd2, 11'd3, 11'd4);
    bus.BLK_READY = 1'b1;
    tick();
    bus.BLK_READY = 1'b0;
    tick();
    checks++;
    if (bus.DMA_EN !== 1'b1) begin
      errors++; $display("FAIL midblock_en: got %b expected 1", bus.DMA_EN);
    end
    rst_n = 1'b0;
    tick();
    obs = {bus.DMA_EN, bus.DMA_PARTIAL, bus.DMA_PARTIAL_START, bus.DMA_PARTIAL_END,
           bus.SRAM_ADDR, bus.BUSY, bus.DONE, bus.ERR, bus.BLOCKS_LEFT};
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL midblock_reset: got %h expected 0", obs);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_three_blocks();
    test_timeout();
    test_abort();
    test_zero_and_busy_start();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d errors", errors);
    $fatal(1);
  end

endmodule
